// File: rtl/invaes_cbc_if.sv
// Signal bundle between the CBC chaining wrapper, its ciphertext source,
// its plaintext sink and the inverse-AES core it drives.
interface invaes_cbc_if #(parameter int CNTW = 16);
  logic            iv_load;
  logic [127:0]    iv;
  logic            ct_valid;
  logic [127:0]    ct_in;
  logic            ct_ready;
  logic            core_ce;
  logic [127:0]    core_ct;
  logic            core_done;
  logic [127:0]    core_pt;
  logic            pt_valid;
  logic [127:0]    pt_out;
  logic            pt_ready;
  logic [CNTW-1:0] blk_count;

  modport slave (
    input  iv_load, iv, ct_valid, ct_in, core_done, core_pt, pt_ready,
    output ct_ready, core_ce, core_ct, pt_valid, pt_out, blk_count
  );

  modport master (
    output iv_load, iv, ct_valid, ct_in, core_done, core_pt, pt_ready,
    input  ct_ready, core_ce, core_ct, pt_valid, pt_out, blk_count
  );
endinterface

// File: rtl/invaes_cbc.sv
// CBC-mode chaining wrapper around an inverse-AES core: issues one ciphertext
// block at a time and XORs the core result with the previous ciphertext (or IV).
module invaes_cbc #(
  parameter int CNTW = 16
) (
  input logic         clk,
  input logic         reset,
  invaes_cbc_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT0, WAIT1, OUT} state_t;

  localparam logic [CNTW-1:0] CountOne = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [127:0]    r_chain;
  logic [127:0]    r_ctReg;
  logic [127:0]    r_ptReg;
  logic [CNTW-1:0] r_blkCount;
  logic            r_ctReady;
  logic            r_coreCe;
  logic            r_ptValid;

  // Handshake flags are registered alongside the state so they toggle with it.
  // WAIT0 exists because core_done is a level that may still be high from the
  // previous block; it must be seen low once before a new result is trusted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_chain    <= '0;
      r_ctReg    <= '0;
      r_ptReg    <= '0;
      r_blkCount <= '0;
      r_ctReady  <= 1'b1;
      r_coreCe   <= 1'b0;
      r_ptValid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.iv_load) begin
            r_chain    <= bus.iv;
            r_blkCount <= '0;
          end
          if (bus.ct_valid) begin
            r_ctReg   <= bus.ct_in;
            r_ctReady <= 1'b0;
            r_coreCe  <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_coreCe <= 1'b0;
          r_state  <= WAIT0;
        end
        WAIT0: begin
          if (!bus.core_done) begin
            r_state <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus.core_done) begin
            r_ptReg   <= bus.core_pt ^ r_chain;
            r_ptValid <= 1'b1;
            r_state   <= OUT;
          end
        end
        OUT: begin
          if (bus.pt_ready) begin
            r_chain    <= r_ctReg;
            r_blkCount <= r_blkCount + CountOne;
            r_ptValid  <= 1'b0;
            r_ctReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ctReady <= 1'b1;
          r_coreCe  <= 1'b0;
          r_ptValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ct_ready  = r_ctReady;
  assign bus.core_ce   = r_coreCe;
  assign bus.core_ct   = r_ctReg;
  assign bus.pt_valid  = r_ptValid;
  assign bus.pt_out    = r_ptReg;
  assign bus.blk_count = r_blkCount;

endmodule

// File: tb/tb_invaes_cbc.sv
// Directed-plus-random bench for invaes_cbc: a behavioural core and a CBC
// reference model (P = D(C) xor previous C) predict every delivered block.
module tb_invaes_cbc;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         iv_load = 1'b0;
  logic [127:0] iv = '0;
  logic         ct_valid = 1'b0;
  logic [127:0] ct_in = '0;
  logic         pt_ready = 1'b0;
  logic         coreDone = 1'b0;
  logic [127:0] corePt = '0;
  logic [127:0] pendPt = '0;

  int nChecks = 0;
  int nFails = 0;
  int coreLat = 2;
  int coreDrop = 0;
  int dropTimer = -1;
  int riseTimer = -1;
  logic         overrideEn = 1'b0;
  logic [127:0] overrideVal = '0;
  logic [127:0] modelChain = '0;
  int unsigned  modelCount = 0;

  invaes_cbc_if #(.CNTW(16)) busA ();
  invaes_cbc_if #(.CNTW(4))  busB ();

  invaes_cbc #(.CNTW(16)) dutA (.clk(clk), .reset(reset), .bus(busA));
  invaes_cbc #(.CNTW(4))  dutB (.clk(clk), .reset(reset), .bus(busB));

  assign busA.iv_load   = iv_load;
  assign busA.iv        = iv;
  assign busA.ct_valid  = ct_valid;
  assign busA.ct_in     = ct_in;
  assign busA.pt_ready  = pt_ready;
  assign busA.core_done = coreDone;
  assign busA.core_pt   = corePt;
  assign busB.iv_load   = iv_load;
  assign busB.iv        = iv;
  assign busB.ct_valid  = ct_valid;
  assign busB.ct_in     = ct_in;
  assign busB.pt_ready  = pt_ready;
  assign busB.core_done = coreDone;
  assign busB.core_pt   = corePt;

  always #5 clk = ~clk;

  function automatic logic [127:0] coreFunc(input logic [127:0] c);
    if (overrideEn) return overrideVal;
    return {c[63:0], c[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural core: done is a level that drops coreDrop cycles after a start
  // strobe and rises with the new result coreLat cycles after it.
  always @(posedge clk) begin
    if (busA.core_ce) begin
      dropTimer <= coreDrop;
      riseTimer <= coreLat;
      pendPt    <= coreFunc(busA.core_ct);
    end else begin
      if (dropTimer == 0) coreDone <= 1'b0;
      if (dropTimer >= 0) dropTimer <= dropTimer - 1;
      if (riseTimer == 0) begin
        coreDone <= 1'b1;
        corePt   <= pendPt;
      end
      if (riseTimer >= 0) riseTimer <= riseTimer - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkCounts();
    checkOutput("blk_count16", 128'(busA.blk_count), 128'(modelCount & 32'hFFFF));
    checkOutput("blk_count4", 128'(busB.blk_count), 128'(modelCount & 32'hF));
  endtask

  // Runs one full block; called at a falling edge and returns at one.
  task automatic applyStimulus(input logic [127:0] c, input bit doIv,
                               input logic [127:0] ivVal, input int hold);
    logic [127:0] expPt;
    int t;
    t = 0;
    while (!busA.ct_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("ct_ready_idle", 128'(busA.ct_ready), 128'(1));
    ct_valid = 1'b1;
    ct_in    = c;
    iv_load  = doIv;
    iv       = ivVal;
    if (doIv) begin
      modelChain = ivVal;
      modelCount = 0;
    end
    expPt = coreFunc(c) ^ modelChain;
    @(negedge clk);
    ct_valid = 1'b0;
    iv_load  = 1'b1;
    iv       = rand128();
    checkOutput("core_ce_issue", 128'(busA.core_ce), 128'(1));
    checkOutput("ct_ready_busy", 128'(busA.ct_ready), 128'(0));
    checkOutput("core_ct", busA.core_ct, c);
    t = 0;
    while (!busA.pt_valid && t < 200) begin
      @(negedge clk);
      t++;
      iv_load = 1'b0;
      if (!busA.pt_valid) checkOutput("core_ce_wait", 128'(busA.core_ce), 128'(0));
    end
    checkOutput("pt_latency", 128'(t), 128'(3 + coreLat));
    for (int h = 0; h < hold; h++) begin
      checkOutput("pt_out_hold", busA.pt_out, expPt);
      checkOutput("pt_valid_hold", 128'(busA.pt_valid), 128'(1));
      checkOutput("ct_ready_hold", 128'(busA.ct_ready), 128'(0));
      checkOutput("core_ce_hold", 128'(busA.core_ce), 128'(0));
      @(negedge clk);
    end
    checkOutput("pt_out", busA.pt_out, expPt);
    checkOutput("pt_out_w4", busB.pt_out, expPt);
    checkCounts();
    pt_ready = 1'b1;
    @(negedge clk);
    pt_ready = 1'b0;
    modelChain = c;
    modelCount++;
    checkOutput("pt_valid_drop", 128'(busA.pt_valid), 128'(0));
    checkOutput("ct_ready_back", 128'(busA.ct_ready), 128'(1));
    checkCounts();
  endtask

  initial begin
    logic [127:0] c1;
    logic [127:0] ivVal;
    int d;

    // Reset state, observed while reset is held and after release.
    repeat (2) @(negedge clk);
    checkOutput("rst_core_ce", 128'(busA.core_ce), 128'(0));
    checkOutput("rst_pt_valid", 128'(busA.pt_valid), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ct_ready", 128'(busA.ct_ready), 128'(1));
    checkOutput("rst_pt_out", busA.pt_out, 128'(0));
    checkOutput("rst_core_ct", busA.core_ct, 128'(0));
    checkCounts();

    // Known-answer block after a standalone iv_load of zero.
    iv_load = 1'b1;
    iv = '0;
    @(negedge clk);
    iv_load = 1'b0;
    modelChain = '0;
    modelCount = 0;
    overrideEn = 1'b1;
    overrideVal = 128'h0f0e0d0c0b0a09080706050403020100;
    coreDrop = 0;
    coreLat = 3;
    applyStimulus(128'h00112233445566778899aabbccddeeff, 1'b0, '0, 0);
    checkOutput("kat1_pt", busA.pt_out, 128'h0f0e0d0c0b0a09080706050403020100);

    // iv_load together with ct_valid: the block chains with the new iv.
    overrideVal = '0;
    ivVal = 128'h000102030405060708090a0b0c0d0e0f;
    c1 = rand128();
    coreDrop = 1;
    coreLat = 4;
    applyStimulus(c1, 1'b1, ivVal, 0);
    checkOutput("kat2_pt_iv", busA.pt_out, ivVal);
    applyStimulus(rand128(), 1'b0, '0, 0);
    checkOutput("kat2_pt_c1", busA.pt_out, c1);
    overrideEn = 1'b0;

    // Stale done held well past the issue strobe, then backpressure.
    coreDrop = 3;
    coreLat = 6;
    applyStimulus(rand128(), 1'b0, '0, 0);
    coreDrop = 0;
    coreLat = 2;
    applyStimulus(rand128(), 1'b0, '0, 5);

    // Reset while waiting for the core result abandons the block.
    coreDrop = 0;
    coreLat = 12;
    ct_valid = 1'b1;
    ct_in = rand128();
    @(negedge clk);
    ct_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_core_ce", 128'(busA.core_ce), 128'(0));
    checkOutput("mid_rst_pt_valid", 128'(busA.pt_valid), 128'(0));
    modelChain = '0;
    modelCount = 0;
    checkCounts();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ct_ready", 128'(busA.ct_ready), 128'(1));
    d = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busA.pt_valid) d++;
    end
    checkOutput("late_done_ignored", 128'(d), 128'(0));
    coreLat = 3;
    applyStimulus(rand128(), 1'b0, '0, 1);

    // Random traffic: 17 blocks after a fresh iv so the narrow counter wraps.
    for (int i = 0; i < 17; i++) begin
      coreDrop = int'($urandom_range(0, 3));
      coreLat = coreDrop + 1 + int'($urandom_range(0, 3));
      applyStimulus(rand128(), i == 0, rand128(), int'($urandom_range(0, 2)));
      if (i == 15) checkOutput("wrap_w4", 128'(busB.blk_count), 128'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/invaes_cbc.md
INVAES_CBC -- requirements
Module: invaes_cbc

Interface
REQ-001 SHALL have parameter CNTW, default 16, width of the block counter.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iv_load  input  1  pulse: capture iv into the chain register.
REQ-005 SHALL have port iv  input  128  initialisation vector.
REQ-006 SHALL have port ct_valid  input  1  upstream ciphertext block available.
REQ-007 SHALL have port ct_in  input  128  ciphertext block.
REQ-008 SHALL have port ct_ready  output  1  block accepted when ct_valid & ct_ready.
REQ-009 SHALL have port core_ce  output  1  load/start strobe to the decryption core.
REQ-010 SHALL have port core_ct  output  128  ciphertext presented to the core.
REQ-011 SHALL have port core_done  input  1  core decryption-complete level.
REQ-012 SHALL have port core_pt  input  128  raw core output, D(C).
REQ-013 SHALL have port pt_valid  output  1  chained plaintext available.
REQ-014 SHALL have port pt_out  output  128  chained plaintext.
REQ-015 SHALL have port pt_ready  input  1  downstream accepts when pt_valid & pt_ready.
REQ-016 SHALL have port blk_count  output  CNTW  blocks delivered since reset/iv_load.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT0, WAIT1, OUT.
REQ-018 IDLE: ct_ready=1; on ct_valid, SHALL register ct_in into ct_reg and go to ISSUE.
REQ-019 ISSUE: SHALL drive core_ce=1 for exactly one cycle, then go to WAIT0.
REQ-020 core_ct SHALL equal ct_reg in every state.
REQ-021 WAIT0: SHALL ignore core_done until it is sampled 0 at least once (stale done from previous block), then go to WAIT1.
REQ-022 WAIT1: on core_done=1, SHALL register pt_reg = core_pt XOR chain and go to OUT.
REQ-023 OUT: pt_valid=1, pt_out=pt_reg; on pt_ready, SHALL set chain <= ct_reg, increment blk_count, and go to IDLE.
REQ-024 ct_ready SHALL be 1 only in IDLE; pt_valid SHALL be 1 only in OUT; core_ce SHALL be 1 only in ISSUE.
REQ-025 Latency: accept at edge t -> core_ce high in cycle t+1; pt_valid rises one cycle after the core_done=1 sample in WAIT1.
REQ-026 pt_out SHALL be held stable while pt_valid=1 and pt_ready=0.
REQ-027 iv_load in IDLE SHALL set chain <= iv and blk_count <= 0; if ct_valid is also high, iv_load takes effect first and the block is accepted, chaining with the new iv.
REQ-028 iv_load outside IDLE SHALL be ignored.
REQ-029 blk_count SHALL wrap from 2^CNTW-1 to 0 with no other effect.
REQ-030 core_done=1 sampled in ISSUE or WAIT0 SHALL NOT produce output.

Reset
REQ-031 reset=1 SHALL asynchronously force: state IDLE, chain=0, ct_reg=0, pt_reg=0, blk_count=0, core_ce=0, pt_valid=0, ct_ready=1 (once reset is released).
REQ-032 Reset during ISSUE/WAIT0/WAIT1/OUT SHALL abandon the block with no pt_valid pulse; a later core_done SHALL be ignored until a new block is issued.

Verification
REQ-033 Reset, iv_load iv=0, C=0x00112233445566778899aabbccddeeff, core model returns 0x0f0e0d0c0b0a09080706050403020100 -> pt_out=0x0f0e...0100, blk_count=1.
REQ-034 iv=0x000102030405060708090a0b0c0d0e0f, core returns 0 -> pt_out=0x000102030405060708090a0b0c0d0e0f; next block C2 with core returning 0 -> pt_out=C1.
REQ-035 core_done held 1 from prior block through ISSUE -> no pt_valid until done drops to 0 and rises again.
REQ-036 pt_ready low 5 cycles in OUT -> pt_out stable, ct_ready=0, core_ce=0 throughout; blk_count increments once.
REQ-037 Reset asserted in WAIT1 -> core_ce=0, pt_valid=0, ct_ready=1 after release, blk_count=0, chain=0.
REQ-038 CNTW=4: 16 blocks delivered -> blk_count=0; iv_load with simultaneous ct_valid in IDLE -> block chains with the new iv.
